// File: rtl/restoring_div8.sv
// restoring_div8: sequential unsigned restoring divider.
// One shift plus one trial subtraction per cycle, so a division takes WIDTH
// iterations. A start/busy/done handshake accepts one division at a time.
// Quotient, remainder and div_by_zero only change when a division completes
// or on reset, so they never show partial values.
module restoring_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] remAcc_q;
  logic [WIDTH-1:0] qAcc_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  // Next-iteration datapath. The running remainder is always below the
  // divisor, so after the shift it fits in WIDTH+1 bits, and the shifted and
  // trial values are carried at that width so the shift can never overflow.
  // A negative trial shows up as bit WIDTH set.
  logic [WIDTH:0]   shiftedRem_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] remAcc_d;
  logic [WIDTH-1:0] qAcc_d;

  // One restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    shiftedRem_d = {remAcc_q, qAcc_q[WIDTH-1]};
    trial_d      = shiftedRem_d - {1'b0, divisor_q};
    qAcc_d       = {qAcc_q[WIDTH-2:0], ~trial_d[WIDTH]};
    if (trial_d[WIDTH]) begin
      remAcc_d = shiftedRem_d[WIDTH-1:0];
    end else begin
      remAcc_d = trial_d[WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remAcc_q    <= '0;
      qAcc_q      <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            if (divisor != '0) begin
              divisor_q <= divisor;
              remAcc_q  <= '0;
              qAcc_q    <= dividend;
              count_q   <= CW'(WIDTH);
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        RUN: begin
          remAcc_q <= remAcc_d;
          qAcc_q   <= qAcc_d;
          count_q  <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            // The old div_by_zero flag is held with the old results and only
            // cleared when this new, valid result is published.
            quotient_q  <= qAcc_d;
            remainder_q <= remAcc_d;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div8.sv
// tb_restoring_div8: scoreboard bench for restoring_div8.
// Expected results are queued when a start is driven and compared whenever
// the divider pulses done.
module tb_restoring_div8;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int assertCount = 0;
  int errorCount  = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sbQ[$];

  restoring_div8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one start pulse (call just after a rising edge); optionally queue
  // the expected result computed from the reference model.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit record);
    exp_t e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    if (record) begin
      e.dvd = dvd;
      e.dvs = dvs;
      if (dvs == 0) begin
        e.q   = '1;
        e.r   = dvd;
        e.dbz = 1'b1;
      end else begin
        e.q   = dvd / dvs;
        e.r   = dvd % dvs;
        e.dbz = 1'b0;
      end
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; report cycles waited and busy cycles seen.
  task automatic waitDone(output int n, output int busyCnt);
    n       = 0;
    busyCnt = 0;
    while (!done && n < 40) begin
      if (busy) busyCnt++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run one division end to end, checking latency and leaving the done cycle.
  task automatic runOne(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int n;
    int b;
    applyStimulus(dvd, dvs, 1'b1);
    waitDone(n, b);
    checkOutput("latency", n, (dvs == 0) ? 0 : W);
    checkOutput("busy_cycles", b, (dvs == 0) ? 0 : W);
    tick(1);
  endtask

  // Scoreboard monitor: on each done pulse pop and compare the oldest result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", div_by_zero, e.dbz);
        checkOutput("busy_at_done", busy, 0);
        if (!e.dbz) begin
          checkOutput("invariant",
                      ((quotient * e.dvs + remainder) == e.dvd) && (remainder < e.dvs), 1);
        end
      end
    end
  end

  initial begin
    int n;
    int b;
    logic [W-1:0] rd;
    logic [W-1:0] rv;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick(2);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    tick(1);

    $display("[TB] basic 100/7 with hold check");
    runOne(8'd100, 8'd7);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_done", done, 0);
      checkOutput("hold_quotient", quotient, 14);
      checkOutput("hold_remainder", remainder, 2);
      tick(1);
    end

    $display("[TB] corner operands");
    runOne(8'd255, 8'd1);
    runOne(8'd5, 8'd10);
    runOne(8'd255, 8'd255);
    runOne(8'd0, 8'd3);

    $display("[TB] divide by zero then recovery");
    runOne(8'd200, 8'd0);
    checkOutput("dbz_held", div_by_zero, 1);
    runOne(8'd9, 8'd4);

    $display("[TB] start while busy is ignored");
    applyStimulus(8'd100, 8'd7, 1'b1);
    tick(2);
    applyStimulus(8'd50, 8'd5, 1'b0);
    waitDone(n, b);
    checkOutput("ignored_latency", n, W - 3);
    tick(3);

    $display("[TB] back-to-back accept in done cycle");
    applyStimulus(8'd100, 8'd7, 1'b1);
    waitDone(n, b);
    checkOutput("b2b_first_latency", n, W);
    applyStimulus(8'd60, 8'd7, 1'b1);
    checkOutput("b2b_no_gap_busy", busy, 1);
    waitDone(n, b);
    checkOutput("b2b_second_latency", n, W);
    tick(1);

    $display("[TB] reset mid-division");
    applyStimulus(8'd200, 8'd3, 1'b1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sbQ.delete();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    runOne(8'd17, 8'd5);

    $display("[TB] random sweep");
    for (int i = 0; i < 2000; i++) begin
      rd = W'($urandom_range(0, 255));
      rv = W'($urandom_range(1, 255));
      runOne(rd, rv);
    end

    tick(2);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errorCount);
    $finish;
  end

endmodule
